// File: rtl/sc_statemachine_move.sv
// Point-movement controller. A Moore FSM turns buttons into clear/load/shift
// commands, repeats a held direction, and locks on game end.
module sc_statemachine_move #(
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = 12500000,
  parameter int unsigned REPEAT_PERIOD = 6250000,
  parameter int unsigned MOVES_W       = 8
) (
  input  logic               SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic               SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic               start_InLow,
  input  logic               up_InLow,
  input  logic               down_InLow,
  input  logic               left_InLow,
  input  logic               right_InLow,
  input  logic               topside_InLow,
  input  logic               bottomside_InLow,
  input  logic               leftside_InLow,
  input  logic               rightside_InLow,
  input  logic               gameover_In,
  input  logic               win_In,
  output logic               clear_OutLow,
  output logic               load0_OutLow,
  output logic               load1_OutLow,
  output logic [1:0]         shiftselection_Out,
  output logic [MOVES_W-1:0] moves_Out,
  output logic               locked_Out,
  output logic [3:0]         state_Out
);

  localparam logic [3:0] ST_RESET = 4'd0;
  localparam logic [3:0] ST_START = 4'd1;
  localparam logic [3:0] ST_CHECK = 4'd2;
  localparam logic [3:0] ST_INIT  = 4'd3;
  localparam logic [3:0] ST_UP    = 4'd4;
  localparam logic [3:0] ST_DOWN  = 4'd5;
  localparam logic [3:0] ST_LEFT  = 4'd6;
  localparam logic [3:0] ST_RIGHT = 4'd7;
  localparam logic [3:0] ST_HOLD  = 4'd8;
  localparam logic [3:0] ST_LOCK  = 4'd9;

  localparam int unsigned REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W_RAW  = $clog2(REPEAT_MAX + 1);
  localparam int unsigned CNT_W      = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam bit          REPEAT_ON  = (REPEAT_EN != 0);

  // The repeat fires on the cycle whose increment would reach the threshold,
  // so the compare is against threshold-1.
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [3:0]         state;
  logic [3:0]         stateNext;
  logic [3:0]         lastDir;
  logic [CNT_W-1:0]   repeatCnt;
  logic               repeatLater;
  logic [MOVES_W-1:0] moves;

  logic       gameEnd;
  logic       allReleased;
  logic [3:0] dirKeys;
  logic       lastKeyAlone;
  logic       lastEdgeFree;
  logic       repeatDue;
  logic       repeatQualify;
  logic       enterMove;
  logic       inMove;

  assign gameEnd     = gameover_In | win_In;
  assign dirKeys     = {up_InLow, down_InLow, left_InLow, right_InLow};
  assign allReleased = start_InLow & (&dirKeys);
  assign inMove      = state inside {ST_UP, ST_DOWN, ST_LEFT, ST_RIGHT};
  assign enterMove   = stateNext inside {ST_UP, ST_DOWN, ST_LEFT, ST_RIGHT};
  assign repeatDue   = (repeatCnt == (repeatLater ? PERIOD_LAST : DELAY_LAST));

  always_comb begin
    lastKeyAlone = 1'b0;
    lastEdgeFree = 1'b0;
    case (lastDir)
      ST_UP: begin
        lastKeyAlone = (dirKeys == 4'b0111);
        lastEdgeFree = topside_InLow;
      end
      ST_DOWN: begin
        lastKeyAlone = (dirKeys == 4'b1011);
        lastEdgeFree = bottomside_InLow;
      end
      ST_LEFT: begin
        lastKeyAlone = (dirKeys == 4'b1101);
        lastEdgeFree = leftside_InLow;
      end
      ST_RIGHT: begin
        lastKeyAlone = (dirKeys == 4'b1110);
        lastEdgeFree = rightside_InLow;
      end
      default: ;
    endcase
    repeatQualify = REPEAT_ON & start_InLow & lastKeyAlone;
  end

  always_comb begin
    stateNext = state;
    if (state != ST_RESET && gameEnd) begin
      stateNext = ST_LOCK;
    end else begin
      case (state)
        ST_RESET: stateNext = ST_START;
        ST_START: stateNext = ST_CHECK;
        ST_CHECK: begin
          // A pressed direction blocked by its edge claims priority and is dropped.
          if (!start_InLow)      stateNext = ST_INIT;
          else if (!up_InLow)    stateNext = topside_InLow    ? ST_UP    : ST_CHECK;
          else if (!down_InLow)  stateNext = bottomside_InLow ? ST_DOWN  : ST_CHECK;
          else if (!left_InLow)  stateNext = leftside_InLow   ? ST_LEFT  : ST_CHECK;
          else if (!right_InLow) stateNext = rightside_InLow  ? ST_RIGHT : ST_CHECK;
          else                   stateNext = ST_CHECK;
        end
        ST_INIT, ST_UP, ST_DOWN, ST_LEFT, ST_RIGHT: stateNext = ST_HOLD;
        ST_HOLD: begin
          if (allReleased)                                   stateNext = ST_CHECK;
          else if (repeatQualify && repeatDue && lastEdgeFree) stateNext = lastDir;
          else                                               stateNext = ST_HOLD;
        end
        ST_LOCK: stateNext = start_InLow ? ST_LOCK : ST_INIT;
        default: stateNext = ST_CHECK;
      endcase
    end
  end

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      state       <= ST_RESET;
      moves       <= '0;
      repeatCnt   <= '0;
      repeatLater <= 1'b0;
      lastDir     <= ST_UP;
    end else begin
      state <= stateNext;

      if (state == ST_INIT)
        moves <= '0;
      else if (inMove && moves != '1)
        moves <= moves + 1'b1;

      if (enterMove) begin
        lastDir     <= stateNext;
        repeatCnt   <= '0;
        repeatLater <= (state == ST_HOLD);
      end else if (state == ST_HOLD) begin
        // A due repeat that is edge-blocked keeps its count and retries.
        if (!repeatQualify)
          repeatCnt <= '0;
        else if (!repeatDue)
          repeatCnt <= repeatCnt + 1'b1;
      end
    end
  end

  always_comb begin
    clear_OutLow       = 1'b1;
    load0_OutLow       = 1'b1;
    load1_OutLow       = 1'b1;
    shiftselection_Out = 2'b11;
    case (state)
      ST_INIT:  clear_OutLow       = 1'b0;
      ST_UP:    load0_OutLow       = 1'b0;
      ST_DOWN:  load1_OutLow       = 1'b0;
      ST_LEFT:  shiftselection_Out = 2'b01;
      ST_RIGHT: shiftselection_Out = 2'b10;
      default: ;
    endcase
  end

  assign moves_Out  = moves;
  assign locked_Out = (state == ST_LOCK);
  assign state_Out  = state;

endmodule

// File: tb/tb_sc_statemachine_move.sv
// Directed bench for sc_statemachine_move with a rule-level reference model
// compared every cycle, plus literal checkpoints.
module tb_sc_statemachine_move;

  localparam int MW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_n = 1'b1, up_n = 1'b1, down_n = 1'b1, left_n = 1'b1, right_n = 1'b1;
  logic top_n = 1'b1, bot_n = 1'b1, lside_n = 1'b1, rside_n = 1'b1;
  logic gameover = 1'b0, win = 1'b0;
  logic clearL, load0L, load1L, locked;
  logic [1:0] shift;
  logic [MW-1:0] moves;
  logic [3:0] st;

  int nCompared = 0;
  int nFail = 0;
  int cntClear = 0, cntLoad0 = 0, cntLoad1 = 0, cntShL = 0, cntShR = 0;

  sc_statemachine_move #(
    .REPEAT_EN(1),
    .REPEAT_DELAY(4),
    .REPEAT_PERIOD(2),
    .MOVES_W(MW)
  ) dut (
    .SC_STATEMACHINEPOINT_CLOCK_50(clk),
    .SC_STATEMACHINEPOINT_RESET_InHigh(rst),
    .start_InLow(start_n),
    .up_InLow(up_n),
    .down_InLow(down_n),
    .left_InLow(left_n),
    .right_InLow(right_n),
    .topside_InLow(top_n),
    .bottomside_InLow(bot_n),
    .leftside_InLow(lside_n),
    .rightside_InLow(rside_n),
    .gameover_In(gameover),
    .win_In(win),
    .clear_OutLow(clearL),
    .load0_OutLow(load0L),
    .load1_OutLow(load1L),
    .shiftselection_Out(shift),
    .moves_Out(moves),
    .locked_Out(locked),
    .state_Out(st)
  );

  always #5 clk = ~clk;

  // Reference: st is the state code, held counts completed qualifying HOLD
  // cycles since the last move, later marks that the first repeat happened.
  typedef struct packed {
    int st;
    int moves;
    int held;
    bit later;
    int last;
  } model_t;

  model_t m;

  function automatic model_t resetModel();
    model_t r;
    r.st = 0; r.moves = 0; r.held = 0; r.later = 1'b0; r.last = 4;
    return r;
  endfunction

  function automatic bit edgeFree(int d);
    case (d)
      4: return top_n;
      5: return bot_n;
      6: return lside_n;
      7: return rside_n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit onlyKey(int d);
    logic [4:0] pressed;
    logic [4:0] want;
    pressed = ~{start_n, up_n, down_n, left_n, right_n};
    want = 5'b01000 >> (d - 4);
    return pressed == want;
  endfunction

  function automatic int checkPick();
    if (!start_n) return 3;
    if (!up_n)    return top_n   ? 4 : 2;
    if (!down_n)  return bot_n   ? 5 : 2;
    if (!left_n)  return lside_n ? 6 : 2;
    if (!right_n) return rside_n ? 7 : 2;
    return 2;
  endfunction

  function automatic model_t stepModel(model_t c);
    model_t n;
    bit anyKey;
    int need;
    n = c;
    anyKey = !(start_n && up_n && down_n && left_n && right_n);
    if (c.st >= 4 && c.st <= 7) n.moves = (c.moves == 7) ? 7 : c.moves + 1;
    if (c.st == 3) n.moves = 0;
    if (c.st != 0 && (gameover || win)) begin
      n.st = 9;
    end else begin
      case (c.st)
        0: n.st = 1;
        1: n.st = 2;
        2: n.st = checkPick();
        3, 4, 5, 6, 7: n.st = 8;
        8: begin
          if (!anyKey) n.st = 2;
          else if (onlyKey(c.last)) begin
            need = c.later ? 2 : 4;
            if (c.held + 1 < need) n.held = c.held + 1;
            else if (edgeFree(c.last)) n.st = c.last;
          end else n.held = 0;
        end
        9: if (!start_n) n.st = 3;
        default: n.st = 2;
      endcase
    end
    if (n.st >= 4 && n.st <= 7) begin
      n.last = n.st;
      n.held = 0;
      n.later = (c.st == 8);
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= resetModel();
    else     m <= stepModel(m);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    @(negedge clk);
    forever begin
      @(negedge clk);
      chk("m_state",  32'(st), m.st);
      chk("m_clear",  32'(clearL), (m.st == 3) ? 0 : 1);
      chk("m_load0",  32'(load0L), (m.st == 4) ? 0 : 1);
      chk("m_load1",  32'(load1L), (m.st == 5) ? 0 : 1);
      chk("m_shift",  32'(shift), (m.st == 6) ? 1 : (m.st == 7) ? 2 : 3);
      chk("m_moves",  32'(moves), m.moves);
      chk("m_locked", 32'(locked), (m.st == 9) ? 1 : 0);
      if (clearL === 1'b0) cntClear++;
      if (load0L === 1'b0) cntLoad0++;
      if (load1L === 1'b0) cntLoad1++;
      if (shift === 2'b01) cntShL++;
      if (shift === 2'b10) cntShR++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic waitState(input int code, input int budget);
    int k;
    k = 0;
    while (st !== 4'(code) && k < budget) begin
      step(1);
      k++;
    end
    chk("wait_state", 32'(st), code);
  endtask

  int c0, c1, cr, cl, cc;

  initial begin
    step(1);
    chk("rst_state", 32'(st), 0);
    chk("rst_clear", 32'(clearL), 1);
    chk("rst_shift", 32'(shift), 3);
    chk("rst_moves", 32'(moves), 0);
    chk("rst_locked", 32'(locked), 0);
    step(1);
    rst = 1'b0;
    step(1);
    chk("start_after_rst", 32'(st), 1);
    step(1);
    chk("check_after_rst", 32'(st), 2);

    // Single left tap
    cl = cntShL;
    left_n = 1'b0; step(1);
    chk("s1_left", 32'(st), 6);
    left_n = 1'b1; step(1);
    chk("s1_hold", 32'(st), 8);
    step(1);
    chk("s1_check", 32'(st), 2);
    chk("s1_moves", 32'(moves), 1);
    chk("s1_shl_pulses", cntShL - cl, 1);

    // Up held 12 cycles: UP at 1, 6, 9, 12
    c0 = cntLoad0;
    up_n = 1'b0; step(12);
    up_n = 1'b1; step(2);
    chk("s2_check", 32'(st), 2);
    chk("s2_load0_pulses", cntLoad0 - c0, 4);
    chk("s2_moves", 32'(moves), 5);

    // Blocked down must not fall through to right
    c1 = cntLoad1; cr = cntShR;
    bot_n = 1'b0; down_n = 1'b0; right_n = 1'b0;
    step(3);
    chk("s3_state", 32'(st), 2);
    chk("s3_load1_pulses", cntLoad1 - c1, 0);
    chk("s3_shr_pulses", cntShR - cr, 0);
    chk("s3_moves", 32'(moves), 5);
    down_n = 1'b1; right_n = 1'b1; bot_n = 1'b1;
    step(1);

    // Clear, then 9 right taps saturate, then clear again
    start_n = 1'b0; step(1);
    chk("s4_init", 32'(st), 3);
    start_n = 1'b1; step(1);
    chk("s4_moves_cleared", 32'(moves), 0);
    step(1);
    cr = cntShR;
    for (int i = 0; i < 9; i++) begin
      right_n = 1'b0; step(1);
      right_n = 1'b1; step(2);
    end
    chk("s4_sat_moves", 32'(moves), 7);
    chk("s4_shr_pulses", cntShR - cr, 9);
    cc = cntClear;
    start_n = 1'b0; step(1);
    chk("s4_init2", 32'(st), 3);
    start_n = 1'b1; step(1);
    chk("s4_moves_zero", 32'(moves), 0);
    step(1);
    chk("s4_clear_pulses", cntClear - cc, 1);

    // Lock during HOLD after a repeat
    cl = cntShL;
    left_n = 1'b0; step(7);
    chk("s5_hold", 32'(st), 8);
    chk("s5_shl_pulses", cntShL - cl, 2);
    gameover = 1'b1; win = 1'b1; step(1);
    chk("s5_lock", 32'(st), 9);
    chk("s5_locked", 32'(locked), 1);
    gameover = 1'b0; win = 1'b0;
    cl = cntShL;
    step(2);
    chk("s5_still_lock", 32'(st), 9);
    chk("s5_moves_frozen", 32'(moves), 2);
    left_n = 1'b1; start_n = 1'b0; step(1);
    chk("s5_init", 32'(st), 3);
    chk("s5_unlocked", 32'(locked), 0);
    chk("s5_no_pulse_in_lock", cntShL - cl, 0);
    start_n = 1'b1; step(2);
    chk("s5_moves_zero", 32'(moves), 0);

    // Reset during RIGHT
    right_n = 1'b0; step(1);
    right_n = 1'b1; step(2);
    chk("s6_moves_before", 32'(moves), 1);
    cr = cntShR;
    right_n = 1'b0; step(1);
    chk("s6_right", 32'(st), 7);
    rst = 1'b1;
    #1;
    chk("s6_rst_state", 32'(st), 0);
    chk("s6_rst_shift", 32'(shift), 3);
    chk("s6_rst_moves", 32'(moves), 0);
    chk("s6_rst_locked", 32'(locked), 0);
    right_n = 1'b1;
    step(2);
    chk("s6_no_pulse", cntShR - cr, 0);
    rst = 1'b0;
    waitState(2, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule
